// File: rtl/e_mdu_core_if.sv
// e_mdu_core_if: issue/read bundle between E-stage control and the multiply/divide unit
interface e_mdu_core_if #(
  parameter int WIDTH = 32
);
  logic             E_Start;
  logic [3:0]       E_MDOp;
  logic [WIDTH-1:0] E_RS;
  logic [WIDTH-1:0] E_RT;
  logic [3:0]       E_MDDataOp;
  logic [WIDTH-1:0] E_MDData;
  logic             E_Busy;
  modport master (output E_Start, E_MDOp, E_RS, E_RT, E_MDDataOp, input E_MDData, E_Busy);
  modport slave (input E_Start, E_MDOp, E_RS, E_RT, E_MDDataOp, output E_MDData, E_Busy);
endinterface

// File: rtl/e_mdu_core.sv
// e_mdu_core: E-stage multiply/divide unit owning HI/LO with modelled latency; define MDU_MADD_EN to enable madd/maddu/msub/msubu
module e_mdu_core #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic         clk,
  input logic         reset_n,
  e_mdu_core_if.slave mdu
);
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  logic [WIDTH-1:0]   hi, lo, p_hi, p_lo;
  logic               p_wr;
  logic [CW-1:0]      cnt;
  logic [3:0]         op;
  logic               sgn, is_mul, is_div, is_mac, is_long, accept, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, b_div, q_u, r_u, q, r;
  logic [2*WIDTH-1:0] prod, mac, res;
  assign op     = mdu.E_MDOp;
  assign sgn    = op == 4'd1 || op == 4'd3 || op == 4'd7 || op == 4'd9;
  assign is_mul = op == 4'd1 || op == 4'd2;
  assign is_div = op == 4'd3 || op == 4'd4;
`ifdef MDU_MADD_EN
  assign is_mac = op >= 4'd7 && op <= 4'd10;
  assign mac    = (op == 4'd9 || op == 4'd10) ? {hi, lo} - prod : {hi, lo} + prod;
`else
  assign is_mac = 1'b0;
  assign mac    = prod;
`endif
  assign is_long      = is_mul | is_div | is_mac;
  assign accept       = mdu.E_Start && cnt == '0;
  assign mdu.E_Busy   = (cnt != '0) | (mdu.E_Start & is_long);
  assign mdu.E_MDData = mdu.E_MDDataOp == 4'd1 ? hi : lo;
  // Sign-extended product and magnitude divide with sign fix-up; a zero divisor is replaced so the divider never sees it
  always_comb begin
    prod  = {{WIDTH{sgn & mdu.E_RS[WIDTH-1]}}, mdu.E_RS} * {{WIDTH{sgn & mdu.E_RT[WIDTH-1]}}, mdu.E_RT};
    a_neg = sgn & mdu.E_RS[WIDTH-1];
    b_neg = sgn & mdu.E_RT[WIDTH-1];
    a_abs = a_neg ? -mdu.E_RS : mdu.E_RS;
    b_abs = b_neg ? -mdu.E_RT : mdu.E_RT;
    b_div = b_abs == '0 ? WIDTH'(1) : b_abs;
    q_u   = a_abs / b_div;
    r_u   = a_abs % b_div;
    q     = (a_neg ^ b_neg) ? -q_u : q_u;
    r     = a_neg ? -r_u : r_u;
    res   = is_div ? {r, q} : is_mac ? mac : prod;
  end
  // Issue captures the pending result and loads the latency counter; the last count commits it to HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi   <= '0;
      lo   <= '0;
      p_hi <= '0;
      p_lo <= '0;
      p_wr <= 1'b0;
      cnt  <= '0;
    end else if (accept && is_long) begin
      {p_hi, p_lo} <= res;
      p_wr         <= !(is_div && mdu.E_RT == '0);
      cnt          <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (accept && op == 4'd5) begin
      hi <= mdu.E_RS;
    end else if (accept && op == 4'd6) begin
      lo <= mdu.E_RS;
    end else if (cnt == CW'(1)) begin
      if (p_wr) {hi, lo} <= {p_hi, p_lo};
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_e_mdu_core.sv
// tb_e_mdu_core: directed vector table plus hand-written busy/reset sequences for e_mdu_core
module tb_e_mdu_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  e_mdu_core_if #(.WIDTH(32)) bus ();
  e_mdu_core #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset_n(reset_n), .mdu(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int n);
    n = 0;
    bus.E_Start = 1'b1;
    bus.E_MDOp = op;
    bus.E_RS = rs;
    bus.E_RT = rt;
    #1;
    if (bus.E_Busy) n++;
    @(posedge clk);
    #1;
    bus.E_Start = 1'b0;
    bus.E_MDOp = 4'd0;
    #1;
    while (bus.E_Busy && n < 40) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask
  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    bus.E_MDDataOp = 4'd1;
    #1;
    h = bus.E_MDData;
    bus.E_MDDataOp = 4'd0;
    #1;
    l = bus.E_MDData;
  endtask
  initial begin
    int n;
    logic [31:0] h, l;
    v[0]  = '{"mult",    4'd1,  32'hFFFFFFFD, 32'd5,        6,  32'hFFFFFFFF, 32'hFFFFFFF1};
    v[1]  = '{"div",     4'd3,  32'hFFFFFFF9, 32'd2,        11, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[2]  = '{"divu",    4'd4,  32'd7,        32'd2,        11, 32'd1,        32'd3};
    v[3]  = '{"multu",   4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 6,  32'hFFFFFFFE, 32'h00000001};
    v[4]  = '{"mthi",    4'd5,  32'h00001234, 32'd0,        0,  32'h00001234, 32'h00000001};
    v[5]  = '{"div0",    4'd3,  32'd5,        32'd0,        11, 32'h00001234, 32'h00000001};
    v[6]  = '{"divmin",  4'd3,  32'h80000000, 32'hFFFFFFFF, 11, 32'h00000000, 32'h80000000};
    v[7]  = '{"mtlo",    4'd6,  32'hFFFFFFFF, 32'd0,        0,  32'h00000000, 32'hFFFFFFFF};
`ifdef MDU_MADD_EN
    v[8]  = '{"maddu",   4'd8,  32'd1,        32'd1,        6,  32'h00000001, 32'h00000000};
`else
    v[8]  = '{"maddu",   4'd8,  32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF};
`endif
    v[9]  = '{"divneg",  4'd3,  32'd7,        32'hFFFFFFFE, 11, 32'h00000001, 32'hFFFFFFFD};
    v[10] = '{"multmax", 4'd1,  32'h7FFFFFFF, 32'h7FFFFFFF, 6,  32'h3FFFFFFF, 32'h00000001};
    v[11] = '{"nop",     4'd0,  32'd99,       32'd1,        0,  32'h3FFFFFFF, 32'h00000001};
    v[12] = '{"op12",    4'd12, 32'd99,       32'd1,        0,  32'h3FFFFFFF, 32'h00000001};
`ifdef MDU_MADD_EN
    v[13] = '{"msub",    4'd9,  32'd1,        32'd2,        6,  32'h3FFFFFFE, 32'hFFFFFFFF};
`else
    v[13] = '{"msub",    4'd9,  32'd1,        32'd2,        0,  32'h3FFFFFFF, 32'h00000001};
`endif
    v[14] = '{"divubig", 4'd4,  32'h80000000, 32'd3,        11, 32'h00000002, 32'h2AAAAAAA};
`ifdef MDU_MADD_EN
    v[15] = '{"madd",    4'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 6,  32'h00000002, 32'h2AAAAAAB};
`else
    v[15] = '{"madd",    4'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'h00000002, 32'h2AAAAAAA};
`endif
    bus.E_Start = 1'b0;
    bus.E_MDOp = 4'd0;
    bus.E_RS = '0;
    bus.E_RT = '0;
    bus.E_MDDataOp = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.E_Busy}, 32'd0);
    read_hl(h, l);
    chk("reset_hi", h, 32'd0);
    chk("reset_lo", l, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].op, v[i].rs, v[i].rt, n);
      read_hl(h, l);
      chk({v[i].name, "_busy"}, n, v[i].busy);
      chk({v[i].name, "_hi"}, h, v[i].hi);
      chk({v[i].name, "_lo"}, l, v[i].lo);
    end
    bus.E_MDDataOp = 4'd7;
    #1;
    chk("sel_other_lo", bus.E_MDData, v[15].lo);
    bus.E_MDDataOp = 4'd0;
    @(posedge clk);
    #1;
    n = 0;
    bus.E_Start = 1'b1;
    bus.E_MDOp = 4'd1;
    bus.E_RS = 32'd2;
    bus.E_RT = 32'd3;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.E_Busy) n++;
      @(posedge clk);
      #1;
      bus.E_Start = i == 2 || i == 3;
      bus.E_MDOp = i == 2 ? 4'd1 : i == 3 ? 4'd6 : 4'd0;
      bus.E_RS = i == 2 ? 32'd4 : 32'h0000DEAD;
      bus.E_RT = 32'd5;
    end
    read_hl(h, l);
    chk("overlap_busy", n, 6);
    chk("overlap_hi", h, 32'd0);
    chk("overlap_lo", l, 32'd6);
    run_op(4'd5, 32'h55, 32'd0, n);
    bus.E_Start = 1'b1;
    bus.E_MDOp = 4'd3;
    bus.E_RS = 32'd100;
    bus.E_RT = 32'd7;
    @(posedge clk);
    #1;
    bus.E_Start = 1'b0;
    bus.E_MDOp = 4'd0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, bus.E_Busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, bus.E_Busy}, 32'd0);
    read_hl(h, l);
    chk("rst_mid_hi", h, 32'd0);
    chk("rst_mid_lo", l, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.E_Busy) n++;
    end
    read_hl(h, l);
    chk("no_late_busy", n, 0);
    chk("no_late_hi", h, 32'd0);
    chk("no_late_lo", l, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
